des_dec_key_sched: RTL

- Iterative DES key scheduler for the decryption direction.
- Accepts a 56-bit post-PC-1 key and emits the 16 round keys in reverse order (K16 first, K1 last), one per accepted output beat.
- Generates each key by right-rotating the C/D halves and applying the existing p_box_56_48 (PC-2) permutation.
- Feeds the round-key port of an iterative DES decrypt datapath; complements the encrypt-side left-rotate key generation.

---
 rtl/des_dec_key_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/des_dec_key_sched.sv
// DES decryption key scheduler (iterative, one round key per accepted beat).
// Emits K16..K1 from a post-PC-1 key by right-rotating the C/D halves and
// applying PC-2 through p_box_56_48.
// Optional build macro DES_KS_ENC_MODE_EN adds a mode_i port; when it is
// sampled high at load, the schedule runs in encrypt order (K1..K16).

// PC-2: selects 48 of the 56 C/D bits. Table entries are 1-based from the MSB
// of {C,D}, so table value t maps to din[56-t].
module p_box_56_48 (
    input  logic [55:0] din,
    output logic [47:0] dout
);
    assign dout = {
        din[42], din[39], din[45], din[32], din[55], din[51],
        din[53], din[28], din[41], din[50], din[35], din[46],
        din[33], din[37], din[44], din[52], din[30], din[48],
        din[40], din[49], din[29], din[36], din[43], din[54],
        din[15], din[4],  din[25], din[19], din[9],  din[1],
        din[26], din[16], din[5],  din[11], din[23], din[8],
        din[12], din[7],  din[17], din[0],  din[22], din[3],
        din[10], din[14], din[6],  din[20], din[27], din[24]
    };
endmodule

module des_dec_key_sched #(
    parameter int unsigned ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DES_KS_ENC_MODE_EN
    input  logic        mode_i,
`endif
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [55:0] key_i,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output logic [47:0] rk_o,
    output logic [3:0]  rk_round_o,
    output logic        rk_last_o,
    output logic        done_o
);
    localparam logic [3:0] LAST_STEP = 4'(ROUNDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, d_q;
    logic [27:0] c_rot, d_rot;
    logic [27:0] c_load, d_load;
    logic [3:0]  step_q;
    logic        done_q;
    logic        enc_q;
    logic        mode_load;
    logic        amt_one;
    logic        load_fire;
    logic        beat_fire;

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

`ifdef DES_KS_ENC_MODE_EN
    assign mode_load = mode_i;

    // Direction is latched at load and held for the whole schedule.
    always_ff @(posedge clk) begin
        if (rst)
            enc_q <= 1'b0;
        else if (load_fire)
            enc_q <= mode_load;
    end
`else
    assign mode_load = 1'b0;
    assign enc_q     = 1'b0;
`endif

    assign load_fire = key_valid_i && key_ready_o;
    assign beat_fire = rk_valid_o && rk_ready_i;

    // Rotate amount applies to the upcoming step (step+1): single shift at
    // steps 1, 8 and 15, double otherwise. The same table serves both
    // directions; encrypt applies its round-0 shift of 1 at load time.
    assign amt_one = (step_q == 4'd0) || (step_q == 4'd7) || (step_q == 4'd14);

    // Next C/D values for a load and for an accepted beat.
    always_comb begin
        c_load = key_i[55:28];
        d_load = key_i[27:0];
        if (mode_load) begin
            c_load = rotl(key_i[55:28], 1'b1);
            d_load = rotl(key_i[27:0], 1'b1);
        end
        c_rot = rotr(c_q, amt_one);
        d_rot = rotr(d_q, amt_one);
        if (enc_q) begin
            c_rot = rotl(c_q, amt_one);
            d_rot = rotl(d_q, amt_one);
        end
    end

    // State, C/D halves, step counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (load_fire) begin
                c_q    <= c_load;
                d_q    <= d_load;
                step_q <= '0;
            end else if (beat_fire) begin
                if (step_q == LAST_STEP) begin
                    done_q <= 1'b1;
                end else begin
                    c_q    <= c_rot;
                    d_q    <= d_rot;
                    step_q <= step_q + 4'd1;
                end
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        key_ready_o = 1'b0;
        rk_valid_o  = 1'b0;
        case (state_q)
            IDLE: begin
                key_ready_o = 1'b1;
                if (key_valid_i)
                    state_d = EMIT;
            end
            EMIT: begin
                rk_valid_o = 1'b1;
                if (rk_ready_i && (step_q == LAST_STEP))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    p_box_56_48 u_pc2 (
        .din  ({c_q, d_q}),
        .dout (rk_o)
    );

    assign rk_round_o = (state_q != EMIT) ? 4'd0 :
                        enc_q             ? step_q : (LAST_STEP - step_q);
    assign rk_last_o  = (state_q == EMIT) && (step_q == LAST_STEP);
    assign done_o     = done_q;

endmodule
